// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg
//   Shared constants for the 7-segment register front-end: write-port address map and the
//   reset values of the mask and mode registers, plus small field helpers.
//   Used by seven_seg_ctrl (import seven_seg_pkg::*).
package seven_seg_pkg;

  // Write-port address map
  localparam logic [1:0] ADDR_NUM  = 2'd0;  // display word (staged to frame end)
  localparam logic [1:0] ADDR_MASK = 2'd1;  // {pointing, blinking}
  localparam logic [1:0] ADDR_MODE = 2'd2;  // mode bits [2:0]
  localparam logic [1:0] ADDR_RSVD = 2'd3;  // reserved, writes ignored

  // Register reset values
  localparam logic [3:0] POINT_RST = 4'hF;  // all dots off (active-low segments)
  localparam logic [3:0] BLINK_RST = 4'h0;
  localparam logic [2:0] MODE_RST  = 3'b001; // hex mode, lower half-word, auto-swap off

  typedef logic [31:0] disp_word_t;

  // Mode register fields
  localparam int unsigned ModeHexBit  = 0;
  localparam int unsigned ModeBankBit = 1;
  localparam int unsigned ModeAutoBit = 2;

  // Dot mask lives in the upper nibble of the mask write, blink mask in the lower one.
  function automatic logic [3:0] mask_point(input logic [7:0] data);
    return data[7:4];
  endfunction

  function automatic logic [3:0] mask_blink(input logic [7:0] data);
    return data[3:0];
  endfunction

endpackage

// File: rtl/seg_prescaler.sv
// seg_prescaler
//   Free-running (FLASH_DIV+1)-bit counter that times the digit scan and the blink clock.
//   Ports:
//     clk_i         system clock
//     rst_i         asynchronous reset, active-high (counter to 0)
//     scan_o        current digit index, cnt[SCAN_DIV+1:SCAN_DIV]
//     flash_clk_o   blink clock, cnt[FLASH_DIV]
//     fe_o          frame-end strobe: cnt[SCAN_DIV+1:0] all ones (next cycle shows digit 0)
//     flash_rise_o  high in the cycle before flash_clk_o goes 0 -> 1
module seg_prescaler #(
  parameter int unsigned SCAN_DIV  = 17,
  parameter int unsigned FLASH_DIV = 24
) (
  input  logic       clk_i,
  input  logic       rst_i,
  output logic [1:0] scan_o,
  output logic       flash_clk_o,
  output logic       fe_o,
  output logic       flash_rise_o
);

  localparam int unsigned CntW = FLASH_DIV + 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  // Wraps naturally at the top; no terminal-count handling needed.
  always_comb begin
    cnt_d = cnt_q + CntW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    scan_o       = cnt_q[SCAN_DIV+1:SCAN_DIV];
    flash_clk_o  = cnt_q[FLASH_DIV];
    fe_o         = &cnt_q[SCAN_DIV+1:0];
    // Strobe is asserted pre-edge so consumers act on the same edge flash_clk rises.
    flash_rise_o = ~cnt_q[FLASH_DIV] & (&cnt_q[FLASH_DIV-1:0]);
  end

endmodule

// File: rtl/seven_seg_ctrl.sv
// seven_seg_ctrl
//   Register/timing front-end for the 7-segment display driver. Holds the display word,
//   dot/blink masks and mode bits written over a simple write port, and provides the digit
//   scan index and blink clock. Display-word writes are staged and committed only at a scan
//   frame boundary so the driver never shows a half-updated word.
//   Optional feature: define SEG_BANK_AUTO_EN to enable automatic half-word bank swapping
//   every AUTO_PERIOD blink-clock rising edges while mode bit2 is set.
//   Ports:
//     clk        system clock
//     rst        asynchronous reset, active-high
//     wr_en      write strobe
//     wr_addr    0 display word, 1 {pointing,blinking}, 2 mode[2:0], 3 reserved
//     wr_data    write data
//     wr_ack     one-cycle pulse the cycle after each accepted write
//     disp_num   committed display word
//     pointing   dot mask per digit, 1 = dot off
//     blinking   blink mask per digit, 1 = blinks with flash_clk
//     mode       [0] hex-digit mode, [1] upper half-word select
//     Scanning   current digit index 0..3
//     flash_clk  blink clock, 50% duty
module seven_seg_ctrl
  import seven_seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 17,
  parameter int unsigned FLASH_DIV   = 24,
  parameter int unsigned AUTO_PERIOD = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [1:0]  wr_addr,
  input  logic [31:0] wr_data,
  output logic        wr_ack,
  output logic [31:0] disp_num,
  output logic [3:0]  pointing,
  output logic [3:0]  blinking,
  output logic [1:0]  mode,
  output logic [1:0]  Scanning,
  output logic        flash_clk
);

  logic fe;
  logic flash_rise;

  seg_prescaler #(
    .SCAN_DIV  (SCAN_DIV),
    .FLASH_DIV (FLASH_DIV)
  ) u_prescaler (
    .clk_i        (clk),
    .rst_i        (rst),
    .scan_o       (Scanning),
    .flash_clk_o  (flash_clk),
    .fe_o         (fe),
    .flash_rise_o (flash_rise)
  );

  disp_word_t disp_q,   disp_d;
  disp_word_t shadow_q, shadow_d;
  logic       pending_q, pending_d;
  logic [3:0] point_q,  point_d;
  logic [3:0] blink_q,  blink_d;
  logic [2:0] mode_q,   mode_d;
  logic       ack_q;

  logic mode_wr;
  assign mode_wr = wr_en && (wr_addr == ADDR_MODE);

`ifdef SEG_BANK_AUTO_EN
  localparam logic [3:0] AutoLast = 4'(AUTO_PERIOD - 1);

  logic [3:0] auto_q, auto_d;
`else
  // Bit2 is stored for software readback compatibility but drives nothing here.
  logic unused_auto;
  assign unused_auto = flash_rise ^ mode_q[ModeAutoBit];
`endif

  always_comb begin
    disp_d    = disp_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    point_d   = point_q;
    blink_d   = blink_q;
    mode_d    = mode_q;

    // Commit a staged word at frame end; a write in this same cycle overrides below.
    if (fe && pending_q) begin
      disp_d    = shadow_q;
      pending_d = 1'b0;
    end

    if (wr_en) begin
      unique case (wr_addr)
        ADDR_NUM: begin
          if (fe) begin
            // Frame-end bypass: newest data wins and nothing is left pending.
            disp_d    = wr_data;
            pending_d = 1'b0;
          end else begin
            shadow_d  = wr_data;
            pending_d = 1'b1;
          end
        end
        ADDR_MASK: begin
          point_d = mask_point(wr_data[7:0]);
          blink_d = mask_blink(wr_data[7:0]);
        end
        ADDR_MODE: begin
          mode_d = wr_data[2:0];
        end
        ADDR_RSVD: begin
        end
        default: begin
        end
      endcase
    end

`ifdef SEG_BANK_AUTO_EN
    auto_d = auto_q;
    if (mode_wr) begin
      auto_d = '0;
    end else if (mode_q[ModeAutoBit] && flash_rise) begin
      if (auto_q == AutoLast) begin
        auto_d              = '0;
        mode_d[ModeBankBit] = ~mode_q[ModeBankBit];
      end else begin
        auto_d = auto_q + 4'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_q    <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      point_q   <= POINT_RST;
      blink_q   <= BLINK_RST;
      mode_q    <= MODE_RST;
      ack_q     <= 1'b0;
    end else begin
      disp_q    <= disp_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      point_q   <= point_d;
      blink_q   <= blink_d;
      mode_q    <= mode_d;
      ack_q     <= wr_en;
    end
  end

`ifdef SEG_BANK_AUTO_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      auto_q <= '0;
    end else begin
      auto_q <= auto_d;
    end
  end
`else
  logic unused_mode_wr;
  assign unused_mode_wr = mode_wr;
`endif

  assign wr_ack   = ack_q;
  assign disp_num = disp_q;
  assign pointing = point_q;
  assign blinking = blink_q;
  assign mode     = mode_q[1:0];

endmodule
